// File: rtl/scarv_cop_palu_mul_sequencer.sv
// Shares one shift-and-add packed multiplier between two requesters (port 0 wins the first tie).
// Latency: request accept to rsp_valid is pw+2 cycles; one operation outstanding at a time.
// Backpressure: no request is accepted until the granted response is consumed via rX_rsp_ready.
// Optional watchdog abort on a stuck multiplier: define SCARV_COP_MUL_SEQ_TIMEOUT_EN.
module scarv_cop_palu_mul_sequencer #(
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  input  logic [2:0]  r0_pw,
  input  logic        r0_high,
  input  logic        r0_ncarry,
  output logic        r0_rsp_valid,
  input  logic        r0_rsp_ready,
  output logic [31:0] r0_rsp_data,
  output logic        r0_rsp_err,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  input  logic [2:0]  r1_pw,
  input  logic        r1_high,
  input  logic        r1_ncarry,
  output logic        r1_rsp_valid,
  input  logic        r1_rsp_ready,
  output logic [31:0] r1_rsp_data,
  output logic        r1_rsp_err,
  output logic        mul_start,
  input  logic        mul_done,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic [2:0]  mul_pw,
  output logic        mul_high,
  output logic        mul_ncarry,
  input  logic [31:0] mul_result
);

  // The watchdog is 6 bits wide, so the abort point must be reachable by it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 63) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 1..63");
  end

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t      state_q, state_d;
  logic        last_grant_q;   // port granted most recently; loses the next tie
  logic        grant_q;        // port owning the operation in flight
  logic [31:0] a_q, b_q;
  logic [2:0]  pw_q;
  logic        high_q, ncarry_q;
  logic [31:0] rsp0_data_q, rsp1_data_q;
  logic        pick;           // port that would be granted this cycle
  logic        accept;
  logic        rsp_fire;
  logic        wdog_hit;

  // Round-robin choice: on a tie the port that did not win last time goes first.
  always_comb begin
    pick     = (r0_valid && r1_valid) ? ~last_grant_q : r1_valid;
    accept   = (state_q == IDLE) && (r0_valid || r1_valid);
    r0_ready = accept && !pick;
    r1_ready = accept && pick;
    rsp_fire = grant_q ? r1_rsp_ready : r0_rsp_ready;
  end

`ifdef SCARV_COP_MUL_SEQ_TIMEOUT_EN
  localparam logic [5:0] WDOG_LAST = 6'(TIMEOUT_CYCLES - 1);

  logic [5:0] wdog_q;
  logic       rsp_err_q;

  assign wdog_hit = (state_q == RUN) && !mul_done && (wdog_q == WDOG_LAST);

  // Watchdog counts RUN cycles; the error flag lives until the response is consumed.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      wdog_q    <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept)                wdog_q <= '0;
      else if (state_q == RUN)   wdog_q <= wdog_q + 6'd1;
      if (wdog_hit)                         rsp_err_q <= 1'b1;
      else if (state_q == RESP && rsp_fire) rsp_err_q <= 1'b0;
    end
  end

  assign r0_rsp_err = rsp_err_q && r0_rsp_valid;
  assign r1_rsp_err = rsp_err_q && r1_rsp_valid;
`else
  assign wdog_hit   = 1'b0;
  assign r0_rsp_err = 1'b0;
  assign r1_rsp_err = 1'b0;
`endif

  // Next-state: accept in IDLE, wait for done (or abort) in RUN, wait for consume in RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (mul_done || wdog_hit) state_d = RESP;
      RESP:    if (rsp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, operand latch on accept and result capture into the owning port's register.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      pw_q         <= '0;
      high_q       <= 1'b0;
      ncarry_q     <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        grant_q      <= pick;
        last_grant_q <= pick;
        a_q          <= pick ? r1_a      : r0_a;
        b_q          <= pick ? r1_b      : r0_b;
        pw_q         <= pick ? r1_pw     : r0_pw;
        high_q       <= pick ? r1_high   : r0_high;
        ncarry_q     <= pick ? r1_ncarry : r0_ncarry;
      end
      // An aborted operation reports zero data.
      if (state_q == RUN && (mul_done || wdog_hit)) begin
        if (grant_q) rsp1_data_q <= mul_done ? mul_result : 32'h0;
        else         rsp0_data_q <= mul_done ? mul_result : 32'h0;
      end
    end
  end

  // Start is held for the whole RUN phase with operands from the latched copy.
  always_comb begin
    mul_start    = (state_q == RUN);
    mul_a        = a_q;
    mul_b        = b_q;
    mul_pw       = pw_q;
    mul_high     = high_q;
    mul_ncarry   = ncarry_q;
    r0_rsp_valid = (state_q == RESP) && !grant_q;
    r1_rsp_valid = (state_q == RESP) && grant_q;
    r0_rsp_data  = rsp0_data_q;
    r1_rsp_data  = rsp1_data_q;
  end

endmodule

// File: tb/tb_scarv_cop_palu_mul_sequencer.sv
module tb_scarv_cop_palu_mul_sequencer;

  localparam int TOUT = 63;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        r0_valid, r0_ready, r0_high, r0_ncarry, r0_rsp_valid, r0_rsp_ready, r0_rsp_err;
  logic [31:0] r0_a, r0_b, r0_rsp_data;
  logic [2:0]  r0_pw;
  logic        r1_valid, r1_ready, r1_high, r1_ncarry, r1_rsp_valid, r1_rsp_ready, r1_rsp_err;
  logic [31:0] r1_a, r1_b, r1_rsp_data;
  logic [2:0]  r1_pw;
  logic        mul_start, mul_done, mul_high, mul_ncarry;
  logic [31:0] mul_a, mul_b, mul_result;
  logic [2:0]  mul_pw;

  scarv_cop_palu_mul_sequencer #(.TIMEOUT_CYCLES(TOUT)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_pw(r0_pw),
    .r0_high(r0_high), .r0_ncarry(r0_ncarry), .r0_rsp_valid(r0_rsp_valid),
    .r0_rsp_ready(r0_rsp_ready), .r0_rsp_data(r0_rsp_data), .r0_rsp_err(r0_rsp_err),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_pw(r1_pw),
    .r1_high(r1_high), .r1_ncarry(r1_ncarry), .r1_rsp_valid(r1_rsp_valid),
    .r1_rsp_ready(r1_rsp_ready), .r1_rsp_data(r1_rsp_data), .r1_rsp_err(r1_rsp_err),
    .mul_start(mul_start), .mul_done(mul_done), .mul_a(mul_a), .mul_b(mul_b),
    .mul_pw(mul_pw), .mul_high(mul_high), .mul_ncarry(mul_ncarry), .mul_result(mul_result)
  );

  always #5 g_clk = ~g_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge g_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, wanted %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stand-in multiplier result: any fixed function of the operands and mode bits.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] pw, input logic hi, input logic nc);
    logic [63:0] p;
    p = nc ? ({32'h0, a ^ b} << pw) : ({32'h0, a} * {32'h0, b});
    return (hi ? p[63:32] : p[31:0]) ^ {29'h0, pw};
  endfunction

  // Multiplier model: done arrives in start cycle pw+1, unless told to hang.
  bit mul_hang = 0;
  int st_cnt = 0;
  always @(posedge g_clk) begin
    if (!g_resetn || !mul_start) st_cnt <= 0;
    else                         st_cnt <= st_cnt + 1;
  end
  assign mul_done   = mul_start && !mul_hang && (st_cnt == int'(mul_pw));
  assign mul_result = mul_done ? ref_mul(mul_a, mul_b, mul_pw, mul_high, mul_ncarry) : 32'hdeadbeef;

  // Response-ready: either directed levels or random backpressure.
  bit   rand_bp = 0;
  logic rdy0_set = 1'b1, rdy1_set = 1'b1, rnd0 = 1'b1, rnd1 = 1'b1;
  always @(posedge g_clk) begin
    #1;
    rnd0 = 1'($urandom_range(0, 1));
    rnd1 = 1'($urandom_range(0, 1));
  end
  assign r0_rsp_ready = rand_bp ? rnd0 : rdy0_set;
  assign r1_rsp_ready = rand_bp ? rnd1 : rdy1_set;

  typedef struct {
    logic [31:0] a, b;
    logic [2:0]  pw;
    logic        hi, nc;
    logic [31:0] data;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q0[$], q1[$];
  int   glog[$];
  int   last_acc[2];
  bit   lat_seen[2];
  int   start_cycles = 0;

  // Drive one request on port p and hold it until accepted; push the expected response then.
  task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] pw, input logic hi, input logic nc);
    exp_t e;
    bit   got;
    got = 0;
    if (p == 0) begin r0_valid = 1; r0_a = a; r0_b = b; r0_pw = pw; r0_high = hi; r0_ncarry = nc; end
    else        begin r1_valid = 1; r1_a = a; r1_b = b; r1_pw = pw; r1_high = hi; r1_ncarry = nc; end
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge g_clk);
      if ((p == 0) ? r0_ready : r1_ready) begin
        got = 1;
        e.a = a; e.b = b; e.pw = pw; e.hi = hi; e.nc = nc; e.acc = cyc;
        if (mul_hang) begin
          e.data = 32'h0; e.err = 1'b1; e.lat = TOUT + 1;
        end else begin
          e.data = ref_mul(a, b, pw, hi, nc); e.err = 1'b0; e.lat = int'(pw) + 2;
        end
        if (p == 0) q0.push_back(e); else q1.push_back(e);
        glog.push_back(p);
        last_acc[p] = cyc;
      end
      @(posedge g_clk); #1;
    end
    if (!got) chk("accept_timeout", 32'd1, 32'd0);
    // Scribble on the request fields: the sequencer must use its own copy.
    if (p == 0) begin r0_valid = 0; r0_a = $urandom; r0_b = $urandom; r0_pw = 3'($urandom); end
    else        begin r1_valid = 0; r1_a = $urandom; r1_b = $urandom; r1_pw = 3'($urandom); end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 500) begin
      @(posedge g_clk); #1; t++;
    end
    if (t >= 500) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    g_resetn = 0;
    q0.delete(); q1.delete();
    lat_seen[0] = 0; lat_seen[1] = 0;
    repeat (2) @(posedge g_clk);
    #1 g_resetn = 1;
  endtask

  // Response monitor for one port: latency on first valid, payload on handshake.
  task automatic mon_port(input int p, input logic vld, input logic rdy,
                          input logic [31:0] dat, input logic err);
    exp_t e;
    if (!vld) return;
    if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
      chk(p == 0 ? "stale_rsp0" : "stale_rsp1", 32'd1, 32'd0);
      return;
    end
    e = (p == 0) ? q0[0] : q1[0];
    if (!lat_seen[p]) begin
      lat_seen[p] = 1;
      chk(p == 0 ? "latency0" : "latency1", 32'(cyc - e.acc), 32'(e.lat));
    end
    if (rdy) begin
      chk(p == 0 ? "data0" : "data1", dat, e.data);
      chk(p == 0 ? "err0" : "err1", {31'h0, err}, {31'h0, e.err});
      if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      lat_seen[p] = 0;
    end
  endtask

  always @(negedge g_clk) begin
    if (g_resetn) begin
      exp_t e;
      if (mul_start) begin
        start_cycles++;
        if (q0.size() == 0 && q1.size() == 0) chk("start_without_op", 32'd1, 32'd0);
        else begin
          e = (q0.size() != 0) ? q0[0] : q1[0];
          if ({mul_a, mul_b, mul_pw, mul_high, mul_ncarry} !== {e.a, e.b, e.pw, e.hi, e.nc})
            chk("mul_operands", mul_a ^ mul_b, e.a ^ e.b);
        end
      end
      if (mul_start || r0_rsp_valid || r1_rsp_valid)
        if (r0_ready || r1_ready) chk("ready_while_busy", 32'd1, 32'd0);
      mon_port(0, r0_rsp_valid, r0_rsp_ready, r0_rsp_data, r0_rsp_err);
      mon_port(1, r1_rsp_valid, r1_rsp_ready, r1_rsp_data, r1_rsp_err);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int   r;
    logic [31:0] held;
    g_resetn = 0;
    r0_valid = 0; r0_a = 0; r0_b = 0; r0_pw = 0; r0_high = 0; r0_ncarry = 0;
    r1_valid = 0; r1_a = 0; r1_b = 0; r1_pw = 0; r1_high = 0; r1_ncarry = 0;
    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    chk("rst_mul_start", {31'h0, mul_start}, 32'h0);
    chk("rst_rsp_valid", {30'h0, r0_rsp_valid, r1_rsp_valid}, 32'h0);
    chk("rst_rsp_err", {30'h0, r0_rsp_err, r1_rsp_err}, 32'h0);
    chk("rst_rsp_data0", r0_rsp_data, 32'h0);
    chk("rst_rsp_data1", r1_rsp_data, 32'h0);
    chk("rst_mul_a", mul_a, 32'h0);
    @(posedge g_clk); #1 g_resetn = 1;

    // Single pw=0 request on port 0.
    start_cycles = 0;
    issue(0, 32'h3, 32'h5, 3'd0, 1'b0, 1'b0);
    wait_idle();
    chk("start_len_pw0", 32'(start_cycles), 32'd1);

    // pw=3 on port 1: four start cycles.
    start_cycles = 0;
    issue(1, 32'h1234_5678, 32'h9abc_def0, 3'd3, 1'b1, 1'b0);
    wait_idle();
    chk("start_len_pw3", 32'(start_cycles), 32'd4);

    // Tie arbitration after reset: r0, then r1, then r0 again.
    do_reset();
    glog.delete();
    fork
      issue(0, 32'h11, 32'h22, 3'd1, 1'b0, 1'b1);
      issue(1, 32'h33, 32'h44, 3'd2, 1'b0, 1'b0);
    join
    wait_idle();
    fork
      issue(0, 32'h55, 32'h66, 3'd0, 1'b1, 1'b1);
      issue(1, 32'h77, 32'h88, 3'd4, 1'b0, 1'b0);
    join
    wait_idle();
    chk("tie_order", {glog[0][7:0], glog[1][7:0], glog[2][7:0]}, 32'h0000_0100);

    // Response backpressure with port 1 waiting.
    rdy0_set = 0;
    issue(0, 32'hcafe_f00d, 32'h0000_0007, 3'd2, 1'b0, 1'b0);
    r = 0;
    do begin @(negedge g_clk); r++; end while (!r0_rsp_valid && r < 50);
    held = ref_mul(32'hcafe_f00d, 32'h7, 3'd2, 1'b0, 1'b0);
    fork issue(1, 32'hface, 32'hb00c, 3'd1, 1'b0, 1'b1); join_none
    repeat (10) begin
      @(negedge g_clk);
      chk("bp_hold", {30'h0, r0_rsp_valid, r1_ready}, 32'h2);
      chk("bp_data", r0_rsp_data, held);
    end
    @(posedge g_clk); #1;
    rdy0_set = 1;
    r = cyc;
    repeat (2) begin @(posedge g_clk); #1; end
    chk("bp_r1_accept", 32'(last_acc[1]), 32'(r + 1));
    wait_idle();

    // Reset in the 2nd start cycle of a pw=5 operation.
    issue(0, 32'h0bad_0bad, 32'h1, 3'd5, 1'b0, 1'b0);
    @(posedge g_clk); #1;
    chk("rr_running", {31'h0, mul_start}, 32'h1);
    g_resetn = 0;
    q0.delete(); q1.delete();
    lat_seen[0] = 0; lat_seen[1] = 0;
    @(posedge g_clk); #1;
    g_resetn = 1;
    @(negedge g_clk);
    chk("rr_idle", {29'h0, mul_start, r0_rsp_valid, r1_rsp_valid}, 32'h0);
    @(posedge g_clk); #1;
    r = cyc;
    issue(1, 32'h5, 32'h6, 3'd0, 1'b0, 1'b0);
    chk("rr_accept_now", 32'(last_acc[1]), 32'(r));
    wait_idle();
    repeat (10) begin @(posedge g_clk); #1; end

    // Multiplier never finishes.
    mul_hang = 1;
    issue(0, 32'h1, 32'h2, 3'd1, 1'b0, 1'b0);
`ifdef SCARV_COP_MUL_SEQ_TIMEOUT_EN
    wait_idle();
    mul_hang = 0;
`else
    repeat (199) begin @(posedge g_clk); #1; end
    @(negedge g_clk);
    chk("hang_start_held", {30'h0, mul_start, r0_rsp_valid}, 32'h2);
    mul_hang = 0;
    do_reset();
`endif

    // Random traffic with random response backpressure.
    rand_bp = 1;
    repeat (40) begin
      r = $urandom_range(1, 3);
      fork
        begin
          if (r[0]) issue(0, $urandom, $urandom, 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        begin
          if (r[1]) issue(1, $urandom, $urandom, 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
      join
      repeat ($urandom_range(0, 3)) begin @(posedge g_clk); #1; end
    end
    wait_idle();
    rand_bp = 0;
    repeat (5) begin @(posedge g_clk); #1; end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
